// File: rtl/fpga_mem_loader.sv
// Push-button memory loader: debounced keypad entry of words into memory.
// Muxes the memory write port between the CPU (RUN) and the loader (EDIT/WRITE).
module fpga_mem_loader #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int ADDR_STEP    = 4,
  parameter int DEBOUNCE_CYC = 100000
) (
  input  logic              hwclk,
  input  logic              reset,
  input  logic [20:0]       pb,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wen,
  output logic              cpu_halt,
  output logic [DATA_W-1:0] disp_data,
  output logic [ADDR_W-1:0] disp_addr,
  output logic              mode_led
);

  localparam int NK = 21;
  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_EDIT  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  localparam logic [4:0] K_ENTER = 5'd16;
  localparam logic [4:0] K_CLEAR = 5'd17;
  localparam logic [4:0] K_SETA  = 5'd18;
  localparam logic [4:0] K_MODE  = 5'd19;
  localparam logic [4:0] K_AZERO = 5'd20;

  logic [NK-1:0] sync1_q, sync2_q;
  logic [NK-1:0] deb_q, deb_d;
  logic [NK-1:0] armed_q, armed_d;
  logic [NK-1:0] pulse;
  logic [CW-1:0] cnt_q [NK];
  logic [CW-1:0] cnt_d [NK];
  logic [1:0]    settle_q;
  logic          sync_ok;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] entry_q, entry_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              key_v;
  logic [4:0]        key_idx;

  assign sync_ok = (settle_q == 2'd2);

  // Two-flop synchronizer; settle counter masks the pipeline fill after reset
  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      settle_q <= '0;
    end else begin
      sync1_q <= pb;
      sync2_q <= sync1_q;
      if (!sync_ok) settle_q <= settle_q + 2'd1;
    end
  end

  // Per-key stable counter; a key must be seen released before it can fire
  always_comb begin
    for (int i = 0; i < NK; i++) begin
      deb_d[i]   = deb_q[i];
      armed_d[i] = armed_q[i];
      cnt_d[i]   = '0;
      pulse[i]   = 1'b0;
      if (sync_ok) begin
        if (sync2_q[i] != deb_q[i]) begin
          if (cnt_q[i] == CNT_MAX) begin
            deb_d[i] = sync2_q[i];
            pulse[i] = sync2_q[i] & armed_q[i];
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end else if (!armed_q[i] && !sync2_q[i]) begin
          if (cnt_q[i] == CNT_MAX) armed_d[i] = 1'b1;
          else cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Debounce state registers
  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      deb_q   <= '0;
      armed_q <= '0;
      for (int i = 0; i < NK; i++) cnt_q[i] <= '0;
    end else begin
      deb_q   <= deb_d;
      armed_q <= armed_d;
      for (int i = 0; i < NK; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Lowest-index pulse wins; the rest are dropped
  always_comb begin
    key_v   = 1'b0;
    key_idx = '0;
    for (int i = NK - 1; i >= 0; i--) begin
      if (pulse[i]) begin
        key_v   = 1'b1;
        key_idx = 5'(i);
      end
    end
  end

  // Loader state machine next-state logic
  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    addr_d  = addr_q;
    unique case (state_q)
      ST_RUN: begin
        if (key_v && key_idx == K_MODE) begin
          state_d = ST_EDIT;
          entry_d = '0;
        end
      end
      ST_EDIT: begin
        if (key_v) begin
          if (key_idx < 5'd16) begin
            entry_d = {entry_q[DATA_W-5:0], key_idx[3:0]};
          end else begin
            case (key_idx)
              K_ENTER: state_d = ST_WRITE;
              K_CLEAR: entry_d = '0;
              K_SETA: begin
                addr_d  = ADDR_W'(entry_q);
                entry_d = '0;
              end
              K_MODE: begin
                state_d = ST_RUN;
                entry_d = '0;
              end
              K_AZERO: addr_d = '0;
              default: ;
            endcase
          end
        end
      end
      ST_WRITE: begin
        state_d = ST_EDIT;
        addr_d  = addr_q + ADDR_W'(ADDR_STEP);
        entry_d = '0;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Loader state registers
  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      entry_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      addr_q  <= addr_d;
    end
  end

  // Memory port mux: CPU passes through only in RUN
  always_comb begin
    if (state_q == ST_RUN) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_wen   = cpu_wen;
    end else begin
      mem_addr  = addr_q;
      mem_wdata = entry_q;
      mem_wen   = (state_q == ST_WRITE);
    end
  end

  assign cpu_halt  = (state_q != ST_RUN);
  assign mode_led  = (state_q != ST_RUN);
  assign disp_data = entry_q;
  assign disp_addr = addr_q;

endmodule

// File: tb/tb_fpga_mem_loader.sv
// Directed bench for fpga_mem_loader with a short debounce window.
// Table of key presses with expected display values, plus timing sequences.
module tb_fpga_mem_loader;

  logic        hwclk = 1'b0;
  logic        reset;
  logic [20:0] pb;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_wen, cpu_halt, mode_led;
  logic [31:0] disp_data, disp_addr;

  fpga_mem_loader #(
    .DATA_W(32), .ADDR_W(32), .ADDR_STEP(4), .DEBOUNCE_CYC(4)
  ) dut (
    .hwclk(hwclk), .reset(reset), .pb(pb),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wen(cpu_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
    .cpu_halt(cpu_halt), .disp_data(disp_data), .disp_addr(disp_addr),
    .mode_led(mode_led)
  );

  always #5 hwclk = ~hwclk;

  int total = 0;
  int bad = 0;
  int wr_cnt = 0;
  logic [31:0] wa [4];
  logic [31:0] wd [4];

  // Log loader writes seen mid-cycle
  always @(negedge hwclk) begin
    if (!reset && mem_wen && cpu_halt) begin
      if (wr_cnt < 4) begin
        wa[wr_cnt] = mem_addr;
        wd[wr_cnt] = mem_wdata;
      end
      wr_cnt++;
    end
  end

  typedef struct {
    int          key;
    logic [31:0] ent;
    logic [31:0] adr;
    logic        mode;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(int k, logic [31:0] e, logic [31:0] a,
                              logic m);
    vec_t v;
    v.key = k; v.ent = e; v.adr = a; v.mode = m;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic press(input int k);
    @(negedge hwclk);
    pb[k] = 1'b1;
    repeat (8) @(negedge hwclk);
    pb[k] = 1'b0;
    repeat (8) @(negedge hwclk);
  endtask

  initial begin
    tv.push_back(mk(19, 32'h0, 32'h0, 1'b1));
    tv.push_back(mk(1, 32'h1, 32'h0, 1'b1));
    tv.push_back(mk(2, 32'h12, 32'h0, 1'b1));
    tv.push_back(mk(3, 32'h123, 32'h0, 1'b1));
    tv.push_back(mk(4, 32'h1234, 32'h0, 1'b1));
    tv.push_back(mk(16, 32'h0, 32'h4, 1'b1));
    tv.push_back(mk(15, 32'hF, 32'h4, 1'b1));
    tv.push_back(mk(1, 32'hF1, 32'h4, 1'b1));
    tv.push_back(mk(2, 32'hF12, 32'h4, 1'b1));
    tv.push_back(mk(3, 32'hF123, 32'h4, 1'b1));
    tv.push_back(mk(4, 32'hF1234, 32'h4, 1'b1));
    tv.push_back(mk(5, 32'hF12345, 32'h4, 1'b1));
    tv.push_back(mk(6, 32'hF123456, 32'h4, 1'b1));
    tv.push_back(mk(7, 32'hF1234567, 32'h4, 1'b1));
    tv.push_back(mk(8, 32'h12345678, 32'h4, 1'b1));
    tv.push_back(mk(17, 32'h0, 32'h4, 1'b1));
    tv.push_back(mk(15, 32'hF, 32'h4, 1'b1));
    tv.push_back(mk(15, 32'hFF, 32'h4, 1'b1));
    tv.push_back(mk(15, 32'hFFF, 32'h4, 1'b1));
    tv.push_back(mk(15, 32'hFFFF, 32'h4, 1'b1));
    tv.push_back(mk(15, 32'hFFFFF, 32'h4, 1'b1));
    tv.push_back(mk(15, 32'hFFFFFF, 32'h4, 1'b1));
    tv.push_back(mk(15, 32'hFFFFFFF, 32'h4, 1'b1));
    tv.push_back(mk(12, 32'hFFFFFFFC, 32'h4, 1'b1));
    tv.push_back(mk(18, 32'h0, 32'hFFFFFFFC, 1'b1));
    tv.push_back(mk(10, 32'hA, 32'hFFFFFFFC, 1'b1));
    tv.push_back(mk(11, 32'hAB, 32'hFFFFFFFC, 1'b1));
    tv.push_back(mk(16, 32'h0, 32'h0, 1'b1));
    tv.push_back(mk(8, 32'h8, 32'h0, 1'b1));
    tv.push_back(mk(18, 32'h0, 32'h8, 1'b1));
    tv.push_back(mk(20, 32'h0, 32'h0, 1'b1));
    tv.push_back(mk(3, 32'h3, 32'h0, 1'b1));
    tv.push_back(mk(18, 32'h0, 32'h3, 1'b1));
    tv.push_back(mk(19, 32'h0, 32'h3, 1'b0));
    tv.push_back(mk(5, 32'h0, 32'h3, 1'b0));
    tv.push_back(mk(17, 32'h0, 32'h3, 1'b0));
    tv.push_back(mk(19, 32'h0, 32'h3, 1'b1));

    reset = 1'b1;
    pb = '0;
    cpu_addr = '0; cpu_wdata = '0; cpu_wen = 1'b0;
    repeat (2) @(negedge hwclk);
    cpu_addr = 32'h10; cpu_wdata = 32'hAB; cpu_wen = 1'b1;
    #1;
    chk("rst_pass_addr", mem_addr, 32'h10);
    chk("rst_pass_wen", mem_wen, 1'b1);
    chk("rst_halt", cpu_halt, 1'b0);
    chk("rst_mode", mode_led, 1'b0);
    chk("rst_entry", disp_data, 32'h0);
    chk("rst_addr", disp_addr, 32'h0);
    @(negedge hwclk);
    reset = 1'b0;
    repeat (12) @(negedge hwclk);

    chk("run_addr", mem_addr, 32'h10);
    chk("run_wdata", mem_wdata, 32'hAB);
    chk("run_wen", mem_wen, 1'b1);
    chk("run_halt", cpu_halt, 1'b0);
    cpu_addr = 32'h20; cpu_wen = 1'b0;
    #1;
    chk("run_comb_addr", mem_addr, 32'h20);
    chk("run_comb_wen", mem_wen, 1'b0);
    cpu_wen = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      press(tv[i].key);
      chk($sformatf("v%0d_entry", i), disp_data, tv[i].ent);
      chk($sformatf("v%0d_addr", i), disp_addr, tv[i].adr);
      chk($sformatf("v%0d_mode", i), mode_led, tv[i].mode);
    end

    chk("wr_count", wr_cnt, 2);
    chk("wr0_addr", wa[0], 32'h0);
    chk("wr0_data", wd[0], 32'h1234);
    chk("wr1_addr", wa[1], 32'hFFFFFFFC);
    chk("wr1_data", wd[1], 32'hAB);

    cpu_addr = 32'h77;
    #1;
    chk("edit_wen_block", mem_wen, 1'b0);
    chk("edit_mem_addr", mem_addr, 32'h3);
    chk("edit_halt", cpu_halt, 1'b1);

    @(negedge hwclk);
    for (int c = 0; c < 20; c++) begin
      pb[5] = ((c / 2) % 2 == 0);
      @(negedge hwclk);
    end
    chk("bounce_quiet", disp_data, 32'h0);
    pb[5] = 1'b1;
    repeat (5) @(negedge hwclk);
    chk("deb_early", disp_data, 32'h0);
    @(negedge hwclk);
    chk("deb_on_time", disp_data, 32'h5);
    repeat (10) @(negedge hwclk);
    chk("deb_no_repeat", disp_data, 32'h5);
    pb[5] = 1'b0;
    repeat (10) @(negedge hwclk);

    press(17);
    chk("clear", disp_data, 32'h0);
    @(negedge hwclk);
    pb[3] = 1'b1; pb[7] = 1'b1;
    repeat (8) @(negedge hwclk);
    pb[3] = 1'b0; pb[7] = 1'b0;
    repeat (8) @(negedge hwclk);
    chk("simul_low_wins", disp_data, 32'h3);

    cpu_wen = 1'b0; cpu_addr = 32'h55; cpu_wdata = 32'h66;
    @(negedge hwclk);
    pb[16] = 1'b1;
    repeat (5) @(negedge hwclk);
    @(posedge hwclk);
    #2;
    chk("wr_active", mem_wen, 1'b1);
    chk("wr_active_addr", mem_addr, 32'h3);
    chk("wr_active_data", mem_wdata, 32'h3);
    reset = 1'b1;
    #1;
    chk("rst_wr_drop", mem_wen, 1'b0);
    chk("rst_wr_pass", mem_addr, 32'h55);
    chk("rst_wr_halt", cpu_halt, 1'b0);
    pb[16] = 1'b0;
    repeat (2) @(negedge hwclk);
    reset = 1'b0;
    repeat (12) @(negedge hwclk);
    chk("post_rst_mode", mode_led, 1'b0);
    chk("post_rst_addr", disp_addr, 32'h0);
    chk("post_rst_entry", disp_data, 32'h0);
    chk("post_rst_wrcnt", wr_cnt, 2);

    pb[19] = 1'b1;
    repeat (10) @(negedge hwclk);
    chk("held_pre_mode", mode_led, 1'b1);
    reset = 1'b1;
    repeat (2) @(negedge hwclk);
    chk("held_rst_mode", mode_led, 1'b0);
    reset = 1'b0;
    repeat (20) @(negedge hwclk);
    chk("held_no_pulse", mode_led, 1'b0);
    pb[19] = 1'b0;
    repeat (16) @(negedge hwclk);
    chk("held_release", mode_led, 1'b0);
    press(19);
    chk("held_repress", mode_led, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
